nibble_serial_adder_ctrl: RTL and testbench
===========================================

Name: nibble_serial_adder_ctrl

Overview:
Sequencer that drives and consumes the team's existing 4-bit ripple-carry adder stage to perform wide additions one nibble per cycle. It accepts a WIDTH-bit operand pair over a valid/ready handshake and feeds nibble slices, least significant first, to the external 4-bit adder. The adder's carry-out is registered and fed back as the next nibble's carry-in. The assembled sum, carry-out and signed-overflow flag are returned over a second valid/ready handshake.

Parameters:
NUM_NIBBLES, 4, number of 4-bit slices per operand (must be >=2); WIDTH = 4*NUM_NIBBLES (16 by default)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands (high only in IDLE)
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_cin  input  1  carry-in for nibble 0
add_a  output  4  nibble of A to adder a[3:0]
add_b  output  4  nibble of B to adder b[3:0]
add_cin  output  1  carry to adder cin
add_sum  input  4  adder sum[3:0]
add_carry  input  1  adder carry
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_sum  output  WIDTH  assembled sum
out_carry  output  1  carry-out of MSB nibble
out_ovf  output  1  two's-complement overflow

Behaviour:
- Reset is asynchronous and active-low; while rst_n=0 and after release:
  - state=IDLE
  - operand, result, index and carry registers = 0
  - out_valid=0, out_sum=0, out_carry=0, out_ovf=0
  - in_ready=1 (nothing is captured while rst_n=0)
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at a rising edge: latch in_a, in_b, in_cin into op_a, op_b, carry_r; clear idx; go to RUN.
- RUN:
  - in_ready=0.
  - Combinationally drive add_a=op_a[4*idx+:4], add_b=op_b[4*idx+:4], add_cin=carry_r.
  - Each edge: result[4*idx+:4]<=add_sum; carry_r<=add_carry; idx<=idx+1.
  - On the edge with idx==NUM_NIBBLES-1:
    - out_carry<=add_carry.
    - out_ovf<=add_carry XOR (add_a[3]^add_b[3]^add_sum[3]), i.e. carry out of bit 3 XOR carry into bit 3.
    - Go to DONE.
  - The external adder is purely combinational; its outputs are sampled in the same cycle add_a/add_b/add_cin are driven.
- Outside RUN: add_a=0, add_b=0, add_cin=0.
- DONE:
  - out_valid=1; out_sum, out_carry and out_ovf are held stable.
  - On out_valid&out_ready: go to IDLE; out_valid drops the next cycle.
  - Results stay readable until the next completion.
- Latency: operands accepted at edge k; out_valid is high from edge k+NUM_NIBBLES. The earliest next acceptance is at edge k+NUM_NIBBLES+2. No overlap: in_valid in RUN/DONE is ignored and in_a/in_b changes have no effect.
- Width rules:
  - out_sum is exactly WIDTH bits; the true sum is {out_carry,out_sum}.
  - in_cin adds 1 at the LSB.
- Boundary conditions:
  - Carry ripples across every nibble boundary via carry_r.
  - All-ones + 1 wraps out_sum to 0 with out_carry=1.
  - out_ready held low stalls indefinitely in DONE.
  - rst_n asserted mid-RUN or mid-DONE aborts immediately: partial result discarded, state IDLE, out_valid=0 at once.

Test Plan:
- Basic add: in_a=0x1234, in_b=0x4321, in_cin=0 -> out_sum=0x5555, out_carry=0, out_ovf=0. out_valid rises exactly 4 cycles after acceptance. add_a sequence 4,3,2,1.
- Full carry ripple: 0xFFFF+0x0001, cin=0 -> out_sum=0x0000, out_carry=1, out_ovf=0. add_cin sequence 0,1,1,1.
- Signed overflow and carry-in:
  - 0x7FFF+0x0001 -> out_sum=0x8000, out_carry=0, out_ovf=1.
  - 0x000A+0x0005 with cin=1 -> out_sum=0x0010, out_carry=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, a concurrent in_valid with new operands is ignored. Then out_ready=1 -> IDLE; the new operands are accepted on the following cycle and produce the correct sum.
- Reset mid-operation: assert rst_n=0 asynchronously while idx=2 -> out_valid=0, in_ready=1, add_a=0 immediately. After release, 0x0F0F+0x00F1 -> 0x1000.
- Idle adder drive: with no traffic for 10 cycles -> add_a=add_b=0, add_cin=0, out_valid=0 throughout.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder sequencer: feeds one nibble per cycle, LSB first, to an external
// combinational 4-bit adder, and chains its carry through carry_r.
module nibble_serial_adder_ctrl #(
  parameter int NUM_NIBBLES = 4,
  parameter int WIDTH       = 4 * NUM_NIBBLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf
);

  localparam int IDX_W = $clog2(NUM_NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIBBLES - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never depends on ready within the same cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   result;
  logic [WIDTH-1:0]   result_next;
  logic [IDX_W-1:0]   idx;
  logic               carry_r;
  logic               last_nibble;
  logic               ovf_next;
  logic [WIDTH-1:0]   out_sum_r;
  logic               out_carry_r;
  logic               out_ovf_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    add_a       = 4'd0;
    add_b       = 4'd0;
    add_cin     = 1'b0;
    last_nibble = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        add_a       = op_a[4*idx +: 4];
        add_b       = op_b[4*idx +: 4];
        add_cin     = carry_r;
        last_nibble = (idx == LAST_IDX);
        if (last_nibble) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Partial result with the current adder slice merged in; on the last
  // nibble this is the complete sum.
  always_comb begin
    result_next = result;
    if (state == RUN) begin
      result_next[4*idx +: 4] = add_sum;
    end
  end

  // Carry into bit 3 is recovered from the MSB's sum bit and its inputs.
  assign ovf_next = add_carry ^ (add_a[3] ^ add_b[3] ^ add_sum[3]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a        <= '0;
      op_b        <= '0;
      result      <= '0;
      idx         <= '0;
      carry_r     <= 1'b0;
      out_sum_r   <= '0;
      out_carry_r <= 1'b0;
      out_ovf_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a    <= in_a;
            op_b    <= in_b;
            carry_r <= in_cin;
            idx     <= '0;
          end
        end
        RUN: begin
          result  <= result_next;
          carry_r <= add_carry;
          idx     <= idx + 1'b1;
          if (last_nibble) begin
            out_sum_r   <= result_next;
            out_carry_r <= add_carry;
            out_ovf_r   <= ovf_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sum   = out_sum_r;
  assign out_carry = out_carry_r;
  assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: directed and random additions checked
// against plain integer arithmetic, with a behavioural 4-bit adder attached.
module tb_nibble_serial_adder_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_carry;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_carry;
  logic         out_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

  nibble_serial_adder_ctrl #(.NUM_NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_carry (add_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ovf   (out_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    return int'(a) + int'(b) + int'(cin);
  endfunction

  function automatic logic exp_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int s;
    s = int'($signed(a)) + int'($signed(b)) + int'(cin);
    return (s > 32767) || (s < -32768);
  endfunction

  // Presents operands in IDLE and returns just after the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    @(negedge clk);
    check("accept_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = W'($urandom);
    in_b     = W'($urandom);
    in_cin   = 1'($urandom);
  endtask

  // Follows the RUN cycles and ends at the first negedge in DONE.
  task automatic run_check(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int ia;
    int ib;
    int mask;
    int full;
    ia   = int'(a);
    ib   = int'(b);
    full = exp_sum(a, b, cin);
    for (int n = 0; n < N; n++) begin
      @(negedge clk);
      mask = (1 << (4 * n)) - 1;
      check("run_add_a", 32'(add_a), 32'((ia >> (4 * n)) & 15));
      check("run_add_b", 32'(add_b), 32'((ib >> (4 * n)) & 15));
      check("run_add_cin", 32'(add_cin), 32'((((ia & mask) + (ib & mask) + int'(cin)) >> (4 * n)) & 1));
      check("run_out_valid", 32'(out_valid), 32'd0);
      check("run_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    check("done_valid", 32'(out_valid), 32'd1);
    check("done_in_ready", 32'(in_ready), 32'd0);
    check("done_sum", 32'(out_sum), 32'(full & 16'hFFFF));
    check("done_carry", 32'(out_carry), 32'((full >> 16) & 1));
    check("done_ovf", 32'(out_ovf), 32'(exp_ovf(a, b, cin)));
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    int           stall;
    int           full;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_carry", 32'(out_carry), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    check("rst_add_a", 32'(add_a), 32'd0);

    // Directed cases
    start_op(16'h1234, 16'h4321, 1'b0); run_check(16'h1234, 16'h4321, 1'b0); finish_op();
    start_op(16'hFFFF, 16'h0001, 1'b0); run_check(16'hFFFF, 16'h0001, 1'b0); finish_op();
    start_op(16'h7FFF, 16'h0001, 1'b0); run_check(16'h7FFF, 16'h0001, 1'b0); finish_op();
    start_op(16'h000A, 16'h0005, 1'b1); run_check(16'h000A, 16'h0005, 1'b1); finish_op();
    start_op(16'hFFFF, 16'h0000, 1'b1); run_check(16'hFFFF, 16'h0000, 1'b1); finish_op();
    start_op(16'h8000, 16'h8000, 1'b0); run_check(16'h8000, 16'h8000, 1'b0); finish_op();

    // Backpressure with a competing operand pair presented while in DONE
    start_op(16'h2468, 16'h1357, 1'b0);
    run_check(16'h2468, 16'h1357, 1'b0);
    in_valid = 1'b1;
    in_a     = 16'h0BAD;
    in_b     = 16'hF00D;
    in_cin   = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_sum", 32'(out_sum), 32'h37BF);
      check("stall_add_a", 32'(add_a), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_cin   = 1'b0;
    run_check(16'h0BAD, 16'hF00D, 1'b1);
    finish_op();

    // Asynchronous reset while idx == 2
    start_op(16'hABCD, 16'h1111, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_add_a", 32'(add_a), 32'd0);
    check("midrst_sum", 32'(out_sum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(16'h0F0F, 16'h00F1, 1'b0); run_check(16'h0F0F, 16'h00F1, 1'b0); finish_op();

    // Idle drive
    repeat (10) begin
      @(negedge clk);
      check("idle_add_a", 32'(add_a), 32'd0);
      check("idle_add_b", 32'(add_b), 32'd0);
      check("idle_add_cin", 32'(add_cin), 32'd0);
      check("idle_valid", 32'(out_valid), 32'd0);
    end

    // Random traffic with random downstream stalls
    for (int t = 0; t < 30; t++) begin
      ra    = W'($urandom);
      rb    = W'($urandom);
      rc    = 1'($urandom_range(0, 1));
      full  = exp_sum(ra, rb, rc);
      start_op(ra, rb, rc);
      run_check(ra, rb, rc);
      stall = $urandom_range(0, 3);
      repeat (stall) begin
        @(negedge clk);
        check("rnd_hold_valid", 32'(out_valid), 32'd1);
        check("rnd_hold_sum", 32'(out_sum), 32'(full & 16'hFFFF));
      end
      finish_op();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
